// File: rtl/div_pkg.sv
// Shared widths and FSM encoding for the 336/80 restoring divider.
package div_pkg;

    localparam int unsigned A_W   = 256;
    localparam int unsigned B_W   = 80;
    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned CNT_W = $clog2(A_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import div_pkg::*;
(
    input  logic [B_W-1:0] r,
    input  logic           bit_in,
    input  logic [B_W-1:0] divisor,
    output logic [B_W-1:0] r_next,
    output logic           qbit
);

    logic [B_W:0] shifted;
    logic [B_W:0] t;

    // {r, bit} stays below 2*divisor, so one extra bit holds the sign of the trial.
    always_comb begin
        shifted = {r, bit_in};
        t       = shifted - {1'b0, divisor};
        qbit    = ~t[B_W];
        r_next  = qbit ? t[B_W-1:0] : shifted[B_W-1:0];
    end

endmodule

// File: rtl/div_336x80.sv
// Iterative restoring divider: 336-bit dividend / 80-bit divisor, one quotient bit per clock.
module div_336x80
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [P_W-1:0] dividend,
    input  logic [B_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W-1:0] quotient,
    output logic [B_W-1:0] remainder,
    output logic           div_zero,
    output logic           ovf
);

    state_t           state_q;
    logic [B_W-1:0]   divisor_q;
    logic [B_W-1:0]   r_q;
    logic [A_W-1:0]   q_q;
    logic [CNT_W-1:0] cnt_q;

    logic [B_W-1:0]   r_next;
    logic             qbit;

    div_step u_step (
        .r       (r_q),
        .bit_in  (q_q[A_W-1]),
        .divisor (divisor_q),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    // The dividend is loaded straight into {R, Q}; its high half is the initial partial remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            divisor_q <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        divisor_q <= divisor;
                        r_q       <= dividend[P_W-1:A_W];
                        q_q       <= dividend[A_W-1:0];
                        in_ready  <= 1'b0;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    if (divisor_q == '0) begin
                        div_zero  <= 1'b1;
                        quotient  <= '1;
                        remainder <= q_q[B_W-1:0];
                        state_q   <= DONE;
                    end else if (r_q >= divisor_q) begin
                        ovf       <= 1'b1;
                        quotient  <= '1;
                        remainder <= '0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    r_q   <= r_next;
                    q_q   <= {q_q[A_W-2:0], qbit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(A_W - 1)) begin
                        quotient  <= {q_q[A_W-2:0], qbit};
                        remainder <= r_next;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        div_zero  <= 1'b0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_336x80.sv
// Scoreboard bench for div_336x80: directed operands, queued expectations, decoupled monitor.
module tb_div_336x80;
    import div_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [P_W-1:0] dividend = '0;
    logic [B_W-1:0] divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [A_W-1:0] quotient;
    logic [B_W-1:0] remainder;
    logic           div_zero;
    logic           ovf;

    div_336x80 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A_W-1:0] q;
        logic [B_W-1:0] r;
        logic           dz;
        logic           ov;
        int             lat;
        int             id;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    task automatic check(input string name, input logic [P_W-1:0] act,
                         input logic [P_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [A_W-1:0] q, input logic [B_W-1:0] r,
                                input logic dz, input logic ov, input int lat, input int id);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat; e.id = id;
        return e;
    endfunction

    // Cycle counter; remembers the edge at which each operation was accepted.
    initial forever begin
        @(posedge clk);
        if (in_valid && in_ready) acc_cyc = cyc;
        cyc++;
    end

    // Monitor: compares each newly presented result against the head of the scoreboard.
    initial begin
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!out_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got quotient %h with empty scoreboard",
                             quotient);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("op%0d_quotient", e.id), P_W'(quotient), P_W'(e.q));
                    check($sformatf("op%0d_remainder", e.id), P_W'(remainder), P_W'(e.r));
                    check($sformatf("op%0d_div_zero", e.id), P_W'(div_zero), P_W'(e.dz));
                    check($sformatf("op%0d_ovf", e.id), P_W'(ovf), P_W'(e.ov));
                    check($sformatf("op%0d_latency", e.id), P_W'(cyc - 1 - acc_cyc),
                          P_W'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [P_W-1:0] dd, input logic [B_W-1:0] dv, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1 (op%0d)", e.id);
        end
        sb.push_back(e);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the operand bus to show the DUT works from its captured copy.
        dividend = ~dd;
        divisor  = ~dv;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (!(in_ready && sb.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!(in_ready && sb.size() == 0)) begin
            n_total++;
            $display("FAIL idle_timeout: op%0d still pending, in_ready got %0b expected 1",
                     id, in_ready);
        end
    endtask

    initial begin
        logic [A_W-1:0] a1, a2;
        logic [B_W-1:0] b1, b2, r2;
        logic [P_W-1:0] p;
        exp_t           e;
        int             n;

        a1 = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
        b1 = 80'hffff_ffff_ffff_ffff_fffe;
        a2 = '1;
        b2 = 80'h8000_0000_0000_0000_0001;
        r2 = 80'h1234;

        #12;
        check("reset_in_ready", P_W'(in_ready), P_W'(1));
        check("reset_out_valid", P_W'(out_valid), P_W'(0));
        check("reset_quotient", P_W'(quotient), P_W'(0));
        check("reset_remainder", P_W'(remainder), P_W'(0));
        check("reset_div_zero", P_W'(div_zero), P_W'(0));
        check("reset_ovf", P_W'(ovf), P_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        p = P_W'(a1) * P_W'(b1);
        issue(p, b1, mk(a1, '0, 1'b0, 1'b0, 258, 1));
        wait_idle(1);
        p = P_W'(a2) * P_W'(b2) + P_W'(r2);
        issue(p, b2, mk(a2, r2, 1'b0, 1'b0, 258, 2));
        wait_idle(2);
        issue(P_W'(1000), B_W'(7), mk(A_W'(142), B_W'(6), 1'b0, 1'b0, 258, 3));
        wait_idle(3);
        issue('1, '1, mk('1, '0, 1'b0, 1'b1, 2, 4));
        wait_idle(4);
        issue(P_W'(16'h1234), '0, mk('1, B_W'(16'h1234), 1'b1, 1'b0, 2, 5));
        wait_idle(5);
        // hi == divisor is the first overflowing value; hi == divisor-1 still fits.
        issue({B_W'(10), A_W'(0)}, B_W'(10), mk('1, '0, 1'b0, 1'b1, 2, 6));
        wait_idle(6);
        issue({B_W'(1), A_W'(0)}, B_W'(2), mk(A_W'(1) << 255, '0, 1'b0, 1'b0, 258, 7));
        wait_idle(7);

        // Back-pressure: hold the result for 50 cycles while poking in_valid.
        out_ready = 1'b0;
        issue(P_W'(12345678), B_W'(1000), mk(A_W'(12345), B_W'(678), 1'b0, 1'b0, 258, 8));
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", P_W'(out_valid), P_W'(1));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_quotient", P_W'(quotient), P_W'(12345));
            check("bp_remainder", P_W'(remainder), P_W'(678));
            check("bp_out_valid", P_W'(out_valid), P_W'(1));
            check("bp_in_ready", P_W'(in_ready), P_W'(0));
            in_valid = i[0];
            dividend = P_W'($urandom);
            divisor  = B_W'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_in_ready", P_W'(in_ready), P_W'(1));
        check("hs_out_valid", P_W'(out_valid), P_W'(0));
        issue(P_W'(1000), B_W'(7), mk(A_W'(142), B_W'(6), 1'b0, 1'b0, 258, 9));
        check("hs_next_accepted", P_W'(in_ready), P_W'(0));
        wait_idle(9);

        // Reset abort mid-RUN, then a clean operation.
        issue(P_W'(1000), B_W'(7), mk(A_W'(142), B_W'(6), 1'b0, 1'b0, 258, 10));
        repeat (101) @(negedge clk);
        rst_n = 1'b0;
        e = sb.pop_back();
        #1;
        check("abort_out_valid", P_W'(out_valid), P_W'(0));
        check("abort_in_ready", P_W'(in_ready), P_W'(1));
        check("abort_quotient", P_W'(quotient), P_W'(0));
        check("abort_remainder", P_W'(remainder), P_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(P_W'(1) << 255, B_W'(2), mk(A_W'(1) << 254, '0, 1'b0, 1'b0, 258, 11));
        wait_idle(11);

        check("scoreboard_drained", P_W'(sb.size()), P_W'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
